stack_param: RTL and testbench

- Parametrised LIFO stack with registered read port, occupancy flags and error reporting.
- Generalises the 4-bit x 5-entry command stack in data width and depth.
- Adds a selectable full-stack policy: overwrite the oldest entry, or reject the push.
- Sits between a command source and a consumer. Uses the same 2-bit command encoding: NOP/PUSH/POP/GET.

---
 rtl/stack_param_if.sv | 28 ++
 rtl/stack_param.sv | 99 +++++++++
 tb/tb_stack_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stack_param_if.sv
// Command/data bus between a command source (master) and the LIFO stack (slave).
interface stack_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       COMMAND;
  logic [IW-1:0]    INDEX;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] DATA_OUT;
  logic             DATA_VALID;
  logic [CW-1:0]    COUNT;
  logic             FULL;
  logic             EMPTY;
  logic             ERROR;

  modport master (
    output COMMAND, INDEX, DATA_IN,
    input  DATA_OUT, DATA_VALID, COUNT, FULL, EMPTY, ERROR
  );

  modport slave (
    input  COMMAND, INDEX, DATA_IN,
    output DATA_OUT, DATA_VALID, COUNT, FULL, EMPTY, ERROR
  );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO stack over a circular buffer: NOP/PUSH/POP/GET commands,
// registered read port, occupancy flags and one-cycle error pulse.
module stack_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter bit WRAP  = 1'b1,
  parameter int IW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        CLK,
  input  logic        RESET,
  stack_param_if.slave bus
);
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    top;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout;
  logic             vld;
  logic             err;

  logic          full, empty;
  logic [IW-1:0] top_inc, top_dec, get_addr;
  logic [IW:0]   diff;
  logic          idx_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign top_inc = (top == LAST_C) ? '0 : top + IW'(1);
  assign top_dec = (top == '0) ? LAST_C : top - IW'(1);

  // Borrow out of the IW+1-bit subtraction means TOP-INDEX went negative;
  // adding DEPTH folds it back into range for any DEPTH, not just powers of 2.
  assign diff     = {1'b0, top} - {1'b0, bus.INDEX};
  assign get_addr = diff[IW] ? diff[IW-1:0] + IW'(DEPTH) : diff[IW-1:0];
  assign idx_ok   = ((CW+1)'(bus.INDEX) < {1'b0, cnt});

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      top  <= LAST_C;
      cnt  <= '0;
      dout <= '0;
      vld  <= 1'b0;
      err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      vld <= 1'b0;
      err <= 1'b0;
      case (bus.COMMAND)
        CMD_NOP: ;
        CMD_PUSH: begin
          // On full with WRAP the pointer advances onto the oldest entry.
          if (!full || WRAP) begin
            top          <= top_inc;
            mem[top_inc] <= bus.DATA_IN;
            if (!full) cnt <= cnt + CW'(1);
          end else begin
            err <= 1'b1;
          end
        end
        CMD_POP: begin
          if (!empty) begin
            dout <= mem[top];
            vld  <= 1'b1;
            top  <= top_dec;
            cnt  <= cnt - CW'(1);
          end else begin
            dout <= '0;
            err  <= 1'b1;
          end
        end
        CMD_GET: begin
          if (idx_ok) begin
            dout <= mem[get_addr];
            vld  <= 1'b1;
          end else begin
            dout <= '0;
            err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.DATA_OUT   = dout;
  assign bus.DATA_VALID = vld;
  assign bus.COUNT      = cnt;
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.ERROR      = err;
endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param: two 4x5 stacks (WRAP=1 / WRAP=0) and a 16x8 stack.
module tb_stack_param;
  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   passed = 0;

  always #5 CLK = ~CLK;

  stack_param_if #(.WIDTH(4),  .DEPTH(5)) a ();
  stack_param_if #(.WIDTH(4),  .DEPTH(5)) b ();
  stack_param_if #(.WIDTH(16), .DEPTH(8)) c ();

  stack_param #(.WIDTH(4),  .DEPTH(5), .WRAP(1'b1)) u_a (.CLK(CLK), .RESET(RESET), .bus(a.slave));
  stack_param #(.WIDTH(4),  .DEPTH(5), .WRAP(1'b0)) u_b (.CLK(CLK), .RESET(RESET), .bus(b.slave));
  stack_param #(.WIDTH(16), .DEPTH(8), .WRAP(1'b1)) u_c (.CLK(CLK), .RESET(RESET), .bus(c.slave));

  // One command per edge; outputs are sampled 1 time unit after the edge.
  task automatic op_a(input logic [1:0] cm, input logic [2:0] ix, input logic [3:0] d);
    a.COMMAND = cm; a.INDEX = ix; a.DATA_IN = d;
    @(posedge CLK); #1;
    a.COMMAND = NOP;
  endtask

  task automatic op_b(input logic [1:0] cm, input logic [2:0] ix, input logic [3:0] d);
    b.COMMAND = cm; b.INDEX = ix; b.DATA_IN = d;
    @(posedge CLK); #1;
    b.COMMAND = NOP;
  endtask

  task automatic op_c(input logic [1:0] cm, input logic [2:0] ix, input logic [15:0] d);
    c.COMMAND = cm; c.INDEX = ix; c.DATA_IN = d;
    @(posedge CLK); #1;
    c.COMMAND = NOP;
  endtask

  task automatic pulse_reset();
    RESET = 1'b0; #2; RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #1;
    total++; if (a.COUNT !== 3'd0) $display("FAIL rst_count got %0d exp 0", a.COUNT); else passed++;
    total++; if (a.EMPTY !== 1'b1 || a.FULL !== 1'b0) $display("FAIL rst_flags got E=%b F=%b exp E=1 F=0", a.EMPTY, a.FULL); else passed++;
    total++; if (a.DATA_OUT !== 4'd0 || a.DATA_VALID !== 1'b0 || a.ERROR !== 1'b0)
      $display("FAIL rst_out got D=%0h V=%b E=%b exp 0/0/0", a.DATA_OUT, a.DATA_VALID, a.ERROR); else passed++;
    total++; if (c.COUNT !== 4'd0 || c.DATA_OUT !== 16'd0) $display("FAIL rst_c got cnt=%0d D=%0h exp 0/0", c.COUNT, c.DATA_OUT); else passed++;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_push_get();
    logic [3:0] exp_d [3] = '{4'd3, 4'd2, 4'd1};
    for (int i = 1; i <= 3; i++) op_a(PUSH, 3'd0, 4'(i));
    total++; if (a.COUNT !== 3'd3 || a.EMPTY !== 1'b0) $display("FAIL push3 got cnt=%0d E=%b exp 3/0", a.COUNT, a.EMPTY); else passed++;
    for (int i = 0; i < 3; i++) begin
      op_a(GET, 3'(i), 4'd0);
      total++;
      if (a.DATA_OUT !== exp_d[i] || a.DATA_VALID !== 1'b1 || a.COUNT !== 3'd3)
        $display("FAIL get%0d got D=%0h V=%b cnt=%0d exp D=%0h V=1 cnt=3", i, a.DATA_OUT, a.DATA_VALID, a.COUNT, exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 1; i <= 5; i++) op_a(PUSH, 3'd0, 4'(i));
    total++; if (a.FULL !== 1'b1) $display("FAIL wrap_full got %b exp 1", a.FULL); else passed++;
    op_a(PUSH, 3'd0, 4'd6);
    total++; if (a.ERROR !== 1'b0 || a.COUNT !== 3'd5 || a.FULL !== 1'b1)
      $display("FAIL wrap_push6 got E=%b cnt=%0d F=%b exp 0/5/1", a.ERROR, a.COUNT, a.FULL); else passed++;
    for (int i = 0; i < 5; i++) begin
      op_a(POP, 3'd0, 4'd0);
      total++;
      if (a.DATA_OUT !== 4'(6 - i) || a.DATA_VALID !== 1'b1)
        $display("FAIL wrap_pop%0d got D=%0h V=%b exp D=%0h V=1", i, a.DATA_OUT, a.DATA_VALID, 6 - i);
      else passed++;
    end
    total++; if (a.EMPTY !== 1'b1) $display("FAIL wrap_empty got %b exp 1", a.EMPTY); else passed++;
  endtask

  task automatic test_reject();
    for (int i = 1; i <= 5; i++) op_b(PUSH, 3'd0, 4'(i));
    op_b(PUSH, 3'd0, 4'd6);
    total++; if (b.ERROR !== 1'b1 || b.DATA_VALID !== 1'b0 || b.COUNT !== 3'd5)
      $display("FAIL rej_push6 got E=%b V=%b cnt=%0d exp 1/0/5", b.ERROR, b.DATA_VALID, b.COUNT); else passed++;
    op_b(NOP, 3'd0, 4'd0);
    total++; if (b.ERROR !== 1'b0) $display("FAIL rej_err_pulse got %b exp 0", b.ERROR); else passed++;
    for (int i = 0; i < 5; i++) begin
      op_b(POP, 3'd0, 4'd0);
      total++;
      if (b.DATA_OUT !== 4'(5 - i) || b.DATA_VALID !== 1'b1)
        $display("FAIL rej_pop%0d got D=%0h V=%b exp D=%0h V=1", i, b.DATA_OUT, b.DATA_VALID, 5 - i);
      else passed++;
    end
  endtask

  task automatic test_errors();
    op_a(POP, 3'd0, 4'd0);
    total++; if (a.ERROR !== 1'b1 || a.DATA_VALID !== 1'b0 || a.DATA_OUT !== 4'd0 || a.COUNT !== 3'd0)
      $display("FAIL pop_empty got E=%b V=%b D=%0h cnt=%0d exp 1/0/0/0", a.ERROR, a.DATA_VALID, a.DATA_OUT, a.COUNT); else passed++;
    op_a(PUSH, 3'd0, 4'hA);
    op_a(PUSH, 3'd0, 4'hB);
    op_a(GET, 3'd1, 4'd0);
    total++; if (a.DATA_OUT !== 4'hA || a.DATA_VALID !== 1'b1) $display("FAIL get_edge got D=%0h V=%b exp A/1", a.DATA_OUT, a.DATA_VALID); else passed++;
    op_a(GET, 3'd3, 4'd0);
    total++; if (a.ERROR !== 1'b1 || a.DATA_OUT !== 4'd0 || a.COUNT !== 3'd2)
      $display("FAIL get_oob got E=%b D=%0h cnt=%0d exp 1/0/2", a.ERROR, a.DATA_OUT, a.COUNT); else passed++;
    op_a(GET, 3'd7, 4'd0);
    total++; if (a.ERROR !== 1'b1 || a.DATA_VALID !== 1'b0) $display("FAIL get_idx7 got E=%b V=%b exp 1/0", a.ERROR, a.DATA_VALID); else passed++;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    op_a(PUSH, 3'd0, 4'd7);
    op_a(PUSH, 3'd0, 4'd8);
    op_a(GET, 3'd0, 4'd0);
    total++; if (a.DATA_OUT !== 4'd8) $display("FAIL mid_pre got %0h exp 8", a.DATA_OUT); else passed++;
    a.COMMAND = POP;
    #3;
    RESET = 1'b0;
    #1;
    total++; if (a.COUNT !== 3'd0 || a.DATA_OUT !== 4'd0 || a.EMPTY !== 1'b1)
      $display("FAIL mid_async got cnt=%0d D=%0h E=%b exp 0/0/1", a.COUNT, a.DATA_OUT, a.EMPTY); else passed++;
    @(posedge CLK); #1;
    total++; if (a.DATA_VALID !== 1'b0 || a.ERROR !== 1'b0) $display("FAIL mid_abort got V=%b E=%b exp 0/0", a.DATA_VALID, a.ERROR); else passed++;
    RESET = 1'b1;
    op_a(POP, 3'd0, 4'd0);
    total++; if (a.ERROR !== 1'b1 || a.DATA_VALID !== 1'b0) $display("FAIL mid_pop got E=%b V=%b exp 1/0", a.ERROR, a.DATA_VALID); else passed++;
  endtask

  task automatic test_deep();
    pulse_reset();
    for (int i = 0; i < 8; i++) op_c(PUSH, 3'd0, 16'hA5A5 + 16'(i));
    total++; if (c.FULL !== 1'b1 || c.COUNT !== 4'd8) $display("FAIL deep_full got F=%b cnt=%0d exp 1/8", c.FULL, c.COUNT); else passed++;
    op_c(GET, 3'd7, 16'd0);
    total++; if (c.DATA_OUT !== 16'hA5A5 || c.DATA_VALID !== 1'b1) $display("FAIL deep_get7 got %0h V=%b exp a5a5/1", c.DATA_OUT, c.DATA_VALID); else passed++;
    op_c(PUSH, 3'd0, 16'hFFFF);
    total++; if (c.ERROR !== 1'b0 || c.COUNT !== 4'd8) $display("FAIL deep_wrap got E=%b cnt=%0d exp 0/8", c.ERROR, c.COUNT); else passed++;
    op_c(GET, 3'd7, 16'd0);
    total++; if (c.DATA_OUT !== 16'hA5A6) $display("FAIL deep_get7w got %0h exp a5a6", c.DATA_OUT); else passed++;
    op_c(GET, 3'd0, 16'd0);
    total++; if (c.DATA_OUT !== 16'hFFFF) $display("FAIL deep_get0 got %0h exp ffff", c.DATA_OUT); else passed++;
    op_c(POP, 3'd0, 16'd0);
    op_c(POP, 3'd0, 16'd0);
    total++; if (c.DATA_OUT !== 16'hA5AC || c.COUNT !== 4'd6) $display("FAIL deep_pop2 got %0h cnt=%0d exp a5ac/6", c.DATA_OUT, c.COUNT); else passed++;
  endtask

  initial begin
    a.COMMAND = NOP; a.INDEX = '0; a.DATA_IN = '0;
    b.COMMAND = NOP; b.INDEX = '0; b.DATA_IN = '0;
    c.COMMAND = NOP; c.INDEX = '0; c.DATA_IN = '0;
    RESET = 1'b1;
    #2;
    test_reset();
    test_push_get();
    test_wrap();
    test_reject();
    test_errors();
    test_reset_mid();
    test_deep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
